// File: rtl/jtag_instruction_register.sv
// jtag_instruction_register: IEEE 1149.1 style IR with shift stage, update latch and opcode decode.
// Define JTAG_IR_IDCODE_EN to decode IDCODE and make it the reset instruction.
module jtag_instruction_register #(
   parameter int unsigned IR_WIDTH = 4,
   parameter logic [IR_WIDTH-1:0] CAPTURE_PATTERN = IR_WIDTH'(2'b01)
) (
   input  logic                TCK,
   input  logic                Reset,
   input  logic                TDI,
   input  logic                ShiftIR,
   input  logic                ClockIR,
   input  logic                UpdateIR,
   output logic                IrTdo,
   output logic [IR_WIDTH-1:0] Instruction,
   output logic                SelExtest,
   output logic                SelSamplePreload,
   output logic                SelIdcode,
   output logic                SelBypass,
   output logic                Mode
);
   localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
   localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(2);
   localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
`ifdef JTAG_IR_IDCODE_EN
   localparam logic ID_EN = 1'b1;
   localparam logic [IR_WIDTH-1:0] RST_OP = OP_IDCODE;
`else
   localparam logic ID_EN = 1'b0;
   localparam logic [IR_WIDTH-1:0] RST_OP = OP_BYPASS;
`endif

   logic [IR_WIDTH-1:0] shift_q, shift_d, instr_q, instr_d;

   always_comb begin
      shift_d = ClockIR ? (ShiftIR ? {TDI, shift_q[IR_WIDTH-1:1]} : CAPTURE_PATTERN) : shift_q;
      instr_d = UpdateIR ? shift_q : instr_q;
   end

   always_ff @(posedge TCK or posedge Reset) begin
      if (Reset) begin
         shift_q <= CAPTURE_PATTERN;
         instr_q <= RST_OP;
      end else begin
         shift_q <= shift_d;
         instr_q <= instr_d;
      end
   end

   // Anything not explicitly recognised falls through to BYPASS, keeping the selects one-hot.
   assign IrTdo            = shift_q[0];
   assign Instruction      = instr_q;
   assign SelExtest        = instr_q == OP_EXTEST;
   assign SelSamplePreload = instr_q == OP_SAMPLE;
   assign SelIdcode        = ID_EN && instr_q == OP_IDCODE;
   assign SelBypass        = !(SelExtest || SelSamplePreload || SelIdcode);
   assign Mode             = SelExtest;
endmodule

// File: tb/tb_jtag_instruction_register.sv
// tb_jtag_instruction_register: model-based checks on every falling TCK edge plus literal pins.
module tb_jtag_instruction_register;
   localparam int W = 4;
`ifdef JTAG_IR_IDCODE_EN
   localparam bit ID_EN = 1'b1;
`else
   localparam bit ID_EN = 1'b0;
`endif
   localparam int RST_OP = ID_EN ? 2 : 15;
   localparam int CAP = 1;

   logic TCK = 1'b0, Reset, TDI, ShiftIR, ClockIR, UpdateIR;
   logic IrTdo, SelExtest, SelSamplePreload, SelIdcode, SelBypass, Mode;
   logic [W-1:0] Instruction;
   int errors = 0, checks = 0;
   int m_shift, m_instr;
   bit live = 1'b0;

   jtag_instruction_register dut (
      .TCK(TCK), .Reset(Reset), .TDI(TDI), .ShiftIR(ShiftIR), .ClockIR(ClockIR),
      .UpdateIR(UpdateIR), .IrTdo(IrTdo), .Instruction(Instruction), .SelExtest(SelExtest),
      .SelSamplePreload(SelSamplePreload), .SelIdcode(SelIdcode), .SelBypass(SelBypass), .Mode(Mode)
   );

   always #5 TCK = ~TCK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // {ext, sample, idcode, bypass}
   function automatic logic [3:0] dec(input int op);
      if (op == 0) return 4'b1000;
      if (op == 1) return 4'b0100;
      if (op == 2 && ID_EN) return 4'b0010;
      return 4'b0001;
   endfunction

   always @(negedge TCK) if (live) begin
      check("model_tdo", 32'(IrTdo), 32'(m_shift % 2));
      check("model_instr", 32'(Instruction), 32'(m_instr));
      check("model_sel", 32'({SelExtest, SelSamplePreload, SelIdcode, SelBypass}), 32'(dec(m_instr)));
      check("model_mode", 32'(Mode), 32'(m_instr == 0));
      check("onehot", 32'($onehot({SelExtest, SelSamplePreload, SelIdcode, SelBypass})), 32'd1);
   end

   task automatic step(input bit c, input bit s, input bit u, input bit t);
      ClockIR = c; ShiftIR = s; UpdateIR = u; TDI = t;
      @(posedge TCK);
      if (Reset) begin
         m_shift = CAP;
         m_instr = RST_OP;
      end else begin
         if (u) m_instr = m_shift;
         if (c) m_shift = s ? (int'(t) * (1 << (W - 1)) + m_shift / 2) : CAP;
      end
      #1;
   endtask

   task automatic shift_in(input logic [W-1:0] v, input int held);
      for (int i = 0; i < W; i++) begin
         step(1, 1, 0, v[i]);
         check("hold_during_shift", 32'(Instruction), 32'(held));
      end
   endtask

   initial begin
      Reset = 1'b1; TDI = 0; ShiftIR = 0; ClockIR = 0; UpdateIR = 0;
      m_shift = CAP; m_instr = RST_OP;
      #1;
      check("reset_instr", 32'(Instruction), ID_EN ? 32'h2 : 32'hF);
      check("reset_tdo", 32'(IrTdo), 32'd1);
      check("reset_sel", 32'({SelIdcode, SelBypass}), ID_EN ? 32'b10 : 32'b01);
      live = 1'b1;
      step(1, 1, 1, 1);
      check("reset_dominates", 32'(Instruction), 32'(RST_OP));
      Reset = 1'b0;
      // capture then scan out the pattern
      step(1, 0, 0, 0);
      check("scan_out0", 32'(IrTdo), 32'd1);
      for (int i = 1; i < 4; i++) begin
         step(1, 1, 0, 0);
         check("scan_out_zero", 32'(IrTdo), 32'd0);
      end
      step(1, 1, 0, 0);
      step(0, 0, 1, 0);
      check("extest_instr", 32'(Instruction), 32'h0);
      check("extest_sel", 32'({SelExtest, Mode}), 32'b11);
      step(0, 1, 0, 1);
      step(0, 0, 0, 1);
      shift_in(4'b0001, 0);
      step(0, 0, 1, 0);
      check("sample_sel", 32'(SelSamplePreload), 32'd1);
      shift_in(4'b0110, 1);
      step(0, 0, 1, 0);
      check("bypass_0110", 32'({SelBypass, Instruction}), 32'h16);
      shift_in(4'b1111, 6);
      step(1, 1, 1, 0);
      check("same_edge_latch", 32'(Instruction), 32'hF);
      check("same_edge_tdo", 32'(IrTdo), 32'd1);
      step(0, 0, 1, 0);
      check("same_edge_shifted", 32'(Instruction), 32'h7);
      shift_in(4'b0010, 7);
      step(0, 0, 1, 0);
      check("idcode_sel", 32'({SelIdcode, SelBypass}), ID_EN ? 32'b10 : 32'b01);
      shift_in(4'b0000, 2);
      step(1, 0, 1, 0);
      check("capture_update_latch", 32'(Instruction), 32'h0);
      step(0, 0, 1, 0);
      check("capture_then_update", 32'(Instruction), 32'h1);
      // reset in the middle of a shift
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      #2;
      Reset = 1'b1;
      m_shift = CAP; m_instr = RST_OP;
      #1;
      check("async_reset_instr", 32'(Instruction), ID_EN ? 32'h2 : 32'hF);
      check("async_reset_tdo", 32'(IrTdo), 32'd1);
      step(1, 1, 1, 0);
      Reset = 1'b0;
      step(0, 0, 1, 0);
      check("post_reset_update", 32'(Instruction), 32'h1);
      step(1, 1, 0, 1);
      check("post_reset_shift_tdo", 32'(IrTdo), 32'd0);
      @(negedge TCK);
      #1;
      live = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/jtag_instruction_register.md
JTAG_INSTRUCTION_REGISTER -- requirements
Module: jtag_instruction_register

Interface
REQ-001 Parameter IR_WIDTH, default 4; width of the shift stage and the instruction latch, minimum 2.
REQ-002 Parameter CAPTURE_PATTERN, default 4'b0001; value loaded into the shift stage on capture, with bits [1:0] fixed at 2'b01.
REQ-003 TCK  input  1  sole clock; every state element samples on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset; driven from the TAP controller Reset output.
REQ-005 TDI  input  1  serial scan-in data.
REQ-006 ShiftIR  input  1  TAP Shift-IR indication; selects shift (1) or capture (0) when ClockIR is asserted.
REQ-007 ClockIR  input  1  IR clock-enable from the TAP controller, sampled on the TCK rising edge.
REQ-008 UpdateIR  input  1  update-enable for the instruction latch, sampled on the TCK rising edge.
REQ-009 IrTdo  output  1  serial scan-out, equal to bit 0 of the shift stage.
REQ-010 Instruction  output  IR_WIDTH  current latched instruction.
REQ-011 SelExtest, SelSamplePreload, SelIdcode, SelBypass  output  1 each  one-hot decoded instruction selects.
REQ-012 Mode  output  1  boundary-scan cells in test mode; equal to SelExtest.

Function
REQ-013 The block SHALL contain an IR_WIDTH-bit shift stage and an IR_WIDTH-bit instruction latch.
REQ-014 ClockIR=1 and ShiftIR=1 on a TCK edge SHALL shift the stage right by one, load TDI into the MSB, and drop the old LSB.
REQ-015 ClockIR=1 and ShiftIR=0 on a TCK edge SHALL load CAPTURE_PATTERN into the shift stage.
REQ-016 ClockIR=0 SHALL hold the shift stage, whatever the value of ShiftIR.
REQ-017 UpdateIR=1 on a TCK edge SHALL copy the pre-edge shift stage into the instruction latch.
REQ-018 If UpdateIR and ClockIR are asserted on the same edge, both actions SHALL occur; the latch receives the pre-edge shift value.
REQ-019 When UpdateIR=0, the instruction latch SHALL hold; the outputs therefore never change during shifting.
REQ-020 IrTdo SHALL be the registered shift-stage bit 0, with no combinational path from TDI.
REQ-021 Opcodes (IR_WIDTH=4) SHALL decode as follows:
- EXTEST = 4'b0000
- SAMPLE/PRELOAD = 4'b0001
- IDCODE = 4'b0010
- BYPASS = 4'b1111
REQ-022 Every unlisted opcode SHALL decode as BYPASS.
REQ-023 The Sel* outputs SHALL be combinational from the instruction latch, with exactly one asserted at all times.
REQ-024 Instruction and the Sel* outputs SHALL change only on the TCK edge following UpdateIR=1, or on Reset.

Reset
REQ-025 Reset=1 SHALL immediately and asynchronously force the shift stage to CAPTURE_PATTERN, making IrTdo=1.
REQ-026 Reset=1 SHALL asynchronously force the instruction latch to its reset opcode (see REQ-030/REQ-031).
REQ-027 An assertion of Reset during a shift or update SHALL abort it; no partial opcode SHALL reach the instruction latch.
REQ-028 On the first TCK edge after Reset deasserts, the block SHALL respond normally to ClockIR and UpdateIR.

Configuration
REQ-029 The macro JTAG_IR_IDCODE_EN SHALL compile IDCODE support in or out.
REQ-030 With JTAG_IR_IDCODE_EN defined:
- 4'b0010 asserts SelIdcode.
- The reset opcode is 4'b0010, so SelIdcode=1 after reset.
REQ-031 With JTAG_IR_IDCODE_EN undefined:
- SelIdcode is tied to 0.
- 4'b0010 decodes as BYPASS.
- The reset opcode is 4'b1111, so SelBypass=1 after reset.

Verification
REQ-032 Reset pulse mid-operation -> Instruction=4'b0010 (macro on) or 4'b1111 (macro off); IrTdo=1; exactly one Sel* high.
REQ-033 One capture edge, then 4 shift edges with TDI=0,0,0,0 -> IrTdo sequence 1,0,0,0 (CAPTURE_PATTERN scanned out); then UpdateIR -> Instruction=4'b0000, SelExtest=1, Mode=1.
REQ-034 Shift in 4'b0001 (LSB first), then UpdateIR -> SelSamplePreload=1; all Sel* outputs stay unchanged during the shift edges.
REQ-035 Shift in 4'b0110, then UpdateIR -> SelBypass=1.
REQ-036 With the stage holding 4'b1111, assert ClockIR, ShiftIR and UpdateIR on the same edge -> the latch receives 4'b1111 and the stage shifts.
REQ-037 Shift in 4'b0010, then UpdateIR -> SelIdcode=1 with the macro on; SelBypass=1 with the macro off.
